// File: rtl/cpu4bit_pkg.sv
// Shared definitions for the 4-bit CPU: ALU operation codes and execute-stage FSM encoding.
// The control unit imports the same opcode constants.
package cpu4bit_pkg;

  localparam int ALU_OP_W = 3;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 3'b100;
  localparam logic [ALU_OP_W-1:0] ALU_SLL = 3'b101;
  localparam logic [ALU_OP_W-1:0] ALU_SRL = 3'b110;
  localparam logic [ALU_OP_W-1:0] ALU_MUL = 3'b111;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

endpackage

// File: rtl/alu_stage_if.sv
// Operand/result bundle between the ALUSrc mux side of the pipeline and the execute stage.
interface alu_stage_if
  import cpu4bit_pkg::*;
#(
  parameter int WIDTH = 4
);
  logic                InValid;
  logic [WIDTH-1:0]    ReadData1;
  logic [WIDTH-1:0]    AluIn;
  logic [ALU_OP_W-1:0] ALUOp;
  logic                Ready;
  logic                Done;
  logic [WIDTH-1:0]    ALUResult;
  logic [WIDTH-1:0]    MulHigh;
  logic                Zero;
  logic                Carry;

  modport master (
    output InValid, ReadData1, AluIn, ALUOp,
    input  Ready, Done, ALUResult, MulHigh, Zero, Carry
  );

  modport slave (
    input  InValid, ReadData1, AluIn, ALUOp,
    output Ready, Done, ALUResult, MulHigh, Zero, Carry
  );
endinterface

// File: rtl/alu_shift_add_mul.sv
// Iterative unsigned shift-add multiplier: one partial product per clock, MUL_CYCLES edges after start.
// done is high during the cycle whose closing edge completes the product; product is valid with it.
module alu_shift_add_mul #(
  parameter int WIDTH      = 4,
  parameter int MUL_CYCLES = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [CW-1:0]      cnt;

  assign acc_next = acc + (b_q[cnt] ? ({{WIDTH{1'b0}}, a_q} << cnt) : '0);
  assign done     = busy && (cnt == CW'(MUL_CYCLES - 1));
  assign product  = acc_next;

  // NOTE: every register here is a few flops, so all of them take the async reset;
  // sequential state is only ever assigned with <= so all flops see pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_q  <= '0;
      b_q  <= '0;
      acc  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      a_q  <= a;
      b_q  <= b;
      acc  <= '0;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      acc <= acc_next;
      cnt <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_stage.sv
// Execute stage of the 4-bit CPU: single-cycle ALU ops plus an iterative multiply,
// with registered result/flags and a Ready/Done handshake.
module alu_stage #(
  parameter int WIDTH      = 4,
  parameter int MUL_CYCLES = 4
) (
  input logic       clock,
  input logic       reset,
  alu_stage_if.slave bus
);
  import cpu4bit_pkg::*;

  logic [0:0]         state;
  logic [WIDTH-1:0]   result_q;
  logic [WIDTH-1:0]   mul_high_q;
  logic               zero_q;
  logic               carry_q;
  logic               done_q;

  logic [WIDTH:0]     sum_ext;
  logic [WIDTH:0]     diff_ext;
  logic [WIDTH-1:0]   op_res;
  logic               op_carry;
  logic               accept;
  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  assign bus.Ready     = (state == ST_IDLE) && !mul_busy;
  assign bus.Done      = done_q;
  assign bus.ALUResult = result_q;
  assign bus.MulHigh   = mul_high_q;
  assign bus.Zero      = zero_q;
  assign bus.Carry     = carry_q;

  assign accept    = bus.InValid && bus.Ready;
  assign mul_start = accept && (bus.ALUOp == ALU_MUL);

  // Bit WIDTH of the widened difference is the borrow (A < B).
  assign sum_ext  = {1'b0, bus.ReadData1} + {1'b0, bus.AluIn};
  assign diff_ext = {1'b0, bus.ReadData1} - {1'b0, bus.AluIn};

  // NOTE: defaults first so no path through the case leaves op_res/op_carry unassigned (no latch).
  always_comb begin
    op_res   = '0;
    op_carry = 1'b0;
    case (bus.ALUOp)
      ALU_ADD: begin op_res = sum_ext[WIDTH-1:0];  op_carry = sum_ext[WIDTH];  end
      ALU_SUB: begin op_res = diff_ext[WIDTH-1:0]; op_carry = diff_ext[WIDTH]; end
      ALU_AND: op_res = bus.ReadData1 & bus.AluIn;
      ALU_OR:  op_res = bus.ReadData1 | bus.AluIn;
      ALU_XOR: op_res = bus.ReadData1 ^ bus.AluIn;
      ALU_SLL: op_res = bus.ReadData1 << bus.AluIn[1:0];
      ALU_SRL: op_res = bus.ReadData1 >> bus.AluIn[1:0];
      default: ;
    endcase
  end

  alu_shift_add_mul #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (mul_start),
    .a       (bus.ReadData1),
    .b       (bus.AluIn),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      result_q   <= '0;
      mul_high_q <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mul_start) begin
            state <= ST_MUL;
          end else if (accept) begin
            result_q <= op_res;
            zero_q   <= (op_res == '0);
            carry_q  <= op_carry;
            done_q   <= 1'b1;
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            result_q   <= mul_product[WIDTH-1:0];
            mul_high_q <= mul_product[2*WIDTH-1:WIDTH];
            zero_q     <= (mul_product[WIDTH-1:0] == '0);
            carry_q    <= (mul_product[2*WIDTH-1:WIDTH] != '0);
            done_q     <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_stage.sv
// Directed self-checking bench for alu_stage: single-cycle ops, multiply handshake, reset abort.
module tb_alu_stage;
  import cpu4bit_pkg::*;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_err;

  alu_stage_if #(.WIDTH(4)) bus ();

  alu_stage #(.WIDTH(4), .MUL_CYCLES(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    bus.InValid   = 1'b1;
    bus.ALUOp     = op;
    bus.ReadData1 = a;
    bus.AluIn     = b;
  endtask

  task automatic single_op(input string tag, input logic [2:0] op, input logic [3:0] a,
                           input logic [3:0] b, input logic [3:0] er, input logic ez,
                           input logic ec, input logic [3:0] ehigh);
    @(negedge clock);
    drive(op, a, b);
    @(posedge clock);
    #1;
    bus.InValid = 1'b0;
    check({tag, "_res"},   bus.ALUResult, er);
    check({tag, "_zero"},  bus.Zero, ez);
    check({tag, "_carry"}, bus.Carry, ec);
    check({tag, "_done"},  bus.Done, 1'b1);
    check({tag, "_ready"}, bus.Ready, 1'b1);
    check({tag, "_high"},  bus.MulHigh, ehigh);
    @(posedge clock);
    #1;
    check({tag, "_done_low"}, bus.Done, 1'b0);
  endtask

  task automatic mul_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] elo, input logic [3:0] ehi, input logic ez,
                        input logic ec);
    int  cycles;
    bit  seen;
    @(negedge clock);
    drive(ALU_MUL, a, b);
    @(posedge clock);
    #1;
    bus.InValid = 1'b0;
    check({tag, "_busy"}, bus.Ready, 1'b0);
    cycles = 0;
    seen   = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clock);
      #1;
      cycles++;
      if (bus.Done) seen = 1'b1;
    end
    check({tag, "_latency"}, cycles[7:0], 8'd4);
    check({tag, "_lo"},    bus.ALUResult, elo);
    check({tag, "_hi"},    bus.MulHigh, ehi);
    check({tag, "_zero"},  bus.Zero, ez);
    check({tag, "_carry"}, bus.Carry, ec);
    check({tag, "_ready"}, bus.Ready, 1'b1);
    @(posedge clock);
    #1;
    check({tag, "_done_low"}, bus.Done, 1'b0);
  endtask

  initial begin
    int done_cnt;
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.InValid   = 1'b0;
    bus.ALUOp     = ALU_ADD;
    bus.ReadData1 = '0;
    bus.AluIn     = '0;
    #12;
    check("rst_res",   bus.ALUResult, 4'd0);
    check("rst_high",  bus.MulHigh, 4'd0);
    check("rst_zero",  bus.Zero, 1'b0);
    check("rst_carry", bus.Carry, 1'b0);
    check("rst_done",  bus.Done, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("post_rst_ready", bus.Ready, 1'b1);
    check("idle_no_done",   bus.Done, 1'b0);

    single_op("add_9_8", ALU_ADD, 4'd9, 4'd8, 4'd1,  1'b0, 1'b1, 4'd0);
    single_op("sub_3_3", ALU_SUB, 4'd3, 4'd3, 4'd0,  1'b1, 1'b0, 4'd0);
    single_op("sub_2_5", ALU_SUB, 4'd2, 4'd5, 4'd13, 1'b0, 1'b1, 4'd0);
    single_op("and",     ALU_AND, 4'hC, 4'hA, 4'h8,  1'b0, 1'b0, 4'd0);
    single_op("or",      ALU_OR,  4'hC, 4'hA, 4'hE,  1'b0, 1'b0, 4'd0);
    single_op("xor",     ALU_XOR, 4'hC, 4'hC, 4'h0,  1'b1, 1'b0, 4'd0);
    single_op("sll",     ALU_SLL, 4'b0011, 4'd2, 4'b1100, 1'b0, 1'b0, 4'd0);
    single_op("srl",     ALU_SRL, 4'b1000, 4'd3, 4'b0001, 1'b0, 1'b0, 4'd0);

    // MUL 7x6 with an ADD 1+2 held on the bus while the stage is busy.
    @(negedge clock);
    drive(ALU_MUL, 4'd7, 4'd6);
    @(posedge clock);
    #1;
    drive(ALU_ADD, 4'd1, 4'd2);
    for (int i = 0; i < 4; i++) begin
      check("mul76_ready_low", bus.Ready, 1'b0);
      check("mul76_no_done",   bus.Done, 1'b0);
      check("mul76_res_hold",  bus.ALUResult, 4'd1);
      @(posedge clock);
      #1;
    end
    check("mul76_done",  bus.Done, 1'b1);
    check("mul76_lo",    bus.ALUResult, 4'hA);
    check("mul76_hi",    bus.MulHigh, 4'h2);
    check("mul76_carry", bus.Carry, 1'b1);
    check("mul76_zero",  bus.Zero, 1'b0);
    check("mul76_ready", bus.Ready, 1'b1);
    @(posedge clock);
    #1;
    bus.InValid = 1'b0;
    check("held_add_done",  bus.Done, 1'b1);
    check("held_add_res",   bus.ALUResult, 4'd3);
    check("held_add_carry", bus.Carry, 1'b0);
    check("held_add_high",  bus.MulHigh, 4'h2);
    @(posedge clock);
    #1;
    check("held_add_done_low", bus.Done, 1'b0);

    // Reset asserted just after E2 of MUL 5x5.
    @(negedge clock);
    drive(ALU_MUL, 4'd5, 4'd5);
    @(posedge clock);
    #1;
    bus.InValid = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("abort_res",   bus.ALUResult, 4'd0);
    check("abort_high",  bus.MulHigh, 4'd0);
    check("abort_carry", bus.Carry, 1'b0);
    check("abort_done",  bus.Done, 1'b0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock);
      #1;
      if (bus.Done) done_cnt++;
    end
    check("abort_no_done_pulse", done_cnt[7:0], 8'd0);
    check("abort_ready",         bus.Ready, 1'b1);

    mul_op("mul_5_5",  4'd5,  4'd5, 4'd9, 4'd1, 1'b0, 1'b1);
    mul_op("mul_15_0", 4'd15, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
    mul_op("mul_15_15", 4'd15, 4'd15, 4'd1, 4'hE, 1'b0, 1'b1);
    single_op("add_after_mul", ALU_ADD, 4'd15, 4'd1, 4'd0, 1'b1, 1'b1, 4'hE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
